led_scan_driver: RTL

Parametrised multiplexed seven-segment display driver for the elevator controller front panel. It replaces the fixed 4-digit floor/status decoder. It scans `NUM_DIGITS` common-anode digits and decodes a 4-bit hex code per digit. Per-digit blanking, blinking and decimal points are supported, and new display contents commit only at frame boundaries so the panel never tears. It sits between the controller FSM (floor number, UES/LES/IS status codes) and the board's digit-select and segment pins.

---
 rtl/led_scan_driver.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/led_scan_driver.sv
// Multiplexed seven-segment scan driver: NUM_DIGITS common-anode digits, hex decode, blank/blink/dp per digit.
// Latency: outputs registered one cycle behind the scan counters; a load is visible within one frame plus one cycle.
// Backpressure: none; load is a fire-and-forget strobe, contents commit only at frame boundaries (tear-free).
//
// Ports:
//   clk          core clock, rising edge
//   reset        asynchronous active-low reset
//   digit_data   4-bit hex code per digit, digit i at [4i+3:4i]
//   dp           decimal point enable per digit
//   blank        force digit dark
//   blink        digit dark during blink-off phase
//   load         one-cycle strobe capturing the four vectors into staging
//   led_sel      one-hot digit select, polarity per SEL_ACTIVE_LOW
//   led_out      {dp, g..a}, polarity per SEG_ACTIVE_LOW
//   frame_done   one-cycle pulse in the output cycle after each frame boundary

module led_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLINK_DIV      = 64,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   led_sel,
  output logic [7:0]              led_out,
  output logic                    frame_done
);

  // Counter widths are clamped to at least one bit so NUM_DIGITS = 1 and
  // BLINK_DIV = 1 still elaborate cleanly.
  localparam int PCNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PCNT_W-1:0]     PCNT_TC   = PCNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FCNT_W-1:0]     FCNT_LAST = FCNT_W'(BLINK_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF   = {NUM_DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [7:0]            SEG_OFF   = {8{SEG_ACTIVE_LOW}};

  // Active-high hex decode, bit order g..a.
  function automatic logic [6:0] f_hex7(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Scan state
  logic [PCNT_W-1:0] r_pcnt;
  logic [IDX_W-1:0]  r_idx;
  logic [FCNT_W-1:0] r_fcnt;
  logic              r_blink_phase;

  // Staging and display register sets
  logic [4*NUM_DIGITS-1:0] r_stg_data, r_dsp_data;
  logic [NUM_DIGITS-1:0]   r_stg_dp,   r_dsp_dp;
  logic [NUM_DIGITS-1:0]   r_stg_blank, r_dsp_blank;
  logic [NUM_DIGITS-1:0]   r_stg_blink, r_dsp_blink;

  logic w_pcnt_tc;
  logic w_idx_last;
  logic w_frame_end;

  assign w_pcnt_tc   = (r_pcnt == PCNT_TC);
  assign w_idx_last  = (r_idx == IDX_LAST);
  assign w_frame_end = w_pcnt_tc & w_idx_last;

  // Prescaler and digit index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pcnt <= '0;
      r_idx  <= '0;
    end else if (w_pcnt_tc) begin
      r_pcnt <= '0;
      r_idx  <= w_idx_last ? '0 : r_idx + 1'b1;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  // Frame counter and blink phase; phase changes only at a frame boundary
  // so a digit never flickers part-way through a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fcnt        <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_end) begin
      if (r_fcnt == FCNT_LAST) begin
        r_fcnt        <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  // Staging: last load in a frame wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stg_data  <= '0;
      r_stg_dp    <= '0;
      r_stg_blank <= '1;
      r_stg_blink <= '0;
    end else if (load) begin
      r_stg_data  <= digit_data;
      r_stg_dp    <= dp;
      r_stg_blank <= blank;
      r_stg_blink <= blink;
    end
  end

  // Display commits at the frame boundary. A load landing on the boundary
  // cycle itself would otherwise miss this commit and wait a whole extra
  // frame, so the live inputs bypass staging in that case.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dsp_data  <= '0;
      r_dsp_dp    <= '0;
      r_dsp_blank <= '1;
      r_dsp_blink <= '0;
    end else if (w_frame_end) begin
      if (load) begin
        r_dsp_data  <= digit_data;
        r_dsp_dp    <= dp;
        r_dsp_blank <= blank;
        r_dsp_blink <= blink;
      end else begin
        r_dsp_data  <= r_stg_data;
        r_dsp_dp    <= r_stg_dp;
        r_dsp_blank <= r_stg_blank;
        r_dsp_blink <= r_stg_blink;
      end
    end
  end

  // Output decode for the digit currently addressed by r_idx
  logic [3:0]            w_code;
  logic [6:0]            w_seg;
  logic                  w_dark;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [NUM_DIGITS-1:0] w_sel_nxt;
  logic [7:0]            w_out_nxt;

  assign w_code   = r_dsp_data[{r_idx, 2'b00} +: 4];
  assign w_seg    = f_hex7(w_code);
  assign w_dark   = r_dsp_blank[r_idx] | (r_dsp_blink[r_idx] & r_blink_phase);
  assign w_onehot = NUM_DIGITS'(1) << r_idx;

  // Polarity is applied by XOR with the all-off pattern just before the
  // output register. The dead-time cycle (pcnt = 0) deselects all digits so
  // the previous digit's segments cannot ghost onto the new one.
  always_comb begin
    w_sel_nxt = SEL_OFF;
    w_out_nxt = SEG_OFF;
    if (!w_dark) begin
      w_out_nxt = {r_dsp_dp[r_idx], w_seg} ^ SEG_OFF;
      if (r_pcnt != '0) begin
        w_sel_nxt = w_onehot ^ SEL_OFF;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_sel    <= SEL_OFF;
      led_out    <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      led_sel    <= w_sel_nxt;
      led_out    <= w_out_nxt;
      frame_done <= w_frame_end;
    end
  end

endmodule
